// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared state encoding, header width and word geometry for the boot loader
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam int HDR_W          = 8;
  localparam int DEF_DATA_WIDTH = 32;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

  localparam int BPW = bytes_per_word(DEF_DATA_WIDTH);

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - host byte stream plus instruction memory write port
interface imem_boot_loader_if
  import imem_boot_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) ();

  logic                  rx_valid;
  logic [HDR_W-1:0]      rx_data;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] imem_A;
  logic [DATA_WIDTH-1:0] imem_WD;
  logic                  imem_WE;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_A, imem_WD, imem_WE
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_A, imem_WD, imem_WE
  );

endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// rtl/imem_boot_loader_byte_word_packer.sv - assembles LSB-first bytes into one instruction word
module imem_boot_loader_byte_word_packer
  import imem_boot_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full
);

  localparam int LANES = bytes_per_word(DATA_WIDTH);
  localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;

  logic [CW-1:0] byte_cnt;

  // Asserted together with the byte that completes the word.
  assign word_full = wr_en && (byte_cnt == CW'(LANES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_cnt == CW'(i)) begin
          word[i*8 +: 8] <= byte_in;
        end
      end
      byte_cnt <= word_full ? '0 : byte_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - fills instruction memory from a length-prefixed byte stream, then releases the core
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_CAPACITY = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  imem_boot_loader_if.slave   bus,
  output logic                core_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t                state;
  state_t                state_next;
  logic [HDR_W-1:0]      n_words;
  logic [HDR_W-1:0]      word_idx;
  logic                  accept;
  logic                  hdr_ok;
  logic                  word_full;
  logic [DATA_WIDTH-1:0] word;

  assign accept = bus.rx_valid && bus.rx_ready;
  assign hdr_ok = (bus.rx_data != '0) && (bus.rx_data <= HDR_W'(MEM_CAPACITY));

  imem_boot_loader_byte_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (state == ST_HDR),
    .wr_en     ((state == ST_LOAD) && accept),
    .byte_in   (bus.rx_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_HDR;
      ST_HDR:   if (accept) state_next = hdr_ok ? ST_LOAD : ST_ERR;
      ST_LOAD:  if (word_full) state_next = ST_WRITE;
      ST_WRITE: state_next = ((word_idx + HDR_W'(1)) == n_words) ? ST_DONE : ST_LOAD;
      ST_DONE:  if (start) state_next = ST_HDR;
      ST_ERR:   if (start) state_next = ST_HDR;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_words  <= '0;
      word_idx <= '0;
    end else if ((state == ST_HDR) && accept && hdr_ok) begin
      n_words  <= bus.rx_data;
      word_idx <= '0;
    end else if (state == ST_WRITE) begin
      word_idx <= word_idx + HDR_W'(1);
    end
  end

  // Every status output decodes the state register, so core_en can never overlap a write.
  always_comb begin
    bus.rx_ready = 1'b0;
    bus.imem_WE  = 1'b0;
    busy         = 1'b0;
    core_en      = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state)
      ST_HDR:   begin bus.rx_ready = 1'b1; busy = 1'b1; end
      ST_LOAD:  begin bus.rx_ready = 1'b1; busy = 1'b1; end
      ST_WRITE: begin bus.imem_WE  = 1'b1; busy = 1'b1; end
      ST_DONE:  begin core_en = 1'b1; done = 1'b1; end
      ST_ERR:   err = 1'b1;
      default:  ;
    endcase
  end

  assign bus.imem_A  = DATA_WIDTH'(word_idx) << 2;
  assign bus.imem_WD = word;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int DW  = 32;
  localparam int CAP = 10;
  localparam int NB  = BPW;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic start = 1'b0;
  logic core_en, busy, done, err;

  imem_boot_loader_if #(.DATA_WIDTH(DW)) bus ();

  imem_boot_loader #(
    .DATA_WIDTH   (DW),
    .MEM_CAPACITY (CAP)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .bus     (bus),
    .core_en (core_en),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int          checks     = 0;
  int          failures   = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  logic [7:0]  img[$];
  int          sess_bytes = 0;
  bit          pend_we    = 1'b0;
  bit          post_we    = 1'b0;
  bit          post_last  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input int w);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < NB; k++) v = v | (32'(img[w*NB+k]) << (8*k));
    return v;
  endfunction

  task automatic chk_zero(input string name);
    chk(name, 32'({bus.rx_ready, bus.imem_WE, core_en, busy, done, err}), 32'd0);
    chk({name, "_addr"}, bus.imem_A, 32'd0);
    chk({name, "_wdata"}, bus.imem_WD, 32'd0);
  endtask

  // Scoreboard: every write is predicted from the accepted byte count and the image queue.
  always @(negedge clk) begin
    if (!rstn) begin
      chk_zero("reset_outputs");
    end else begin
      chk("we_timing", 32'(bus.imem_WE), 32'(pend_we));
      if (bus.imem_WE) begin
        log_a.push_back(bus.imem_A);
        log_d.push_back(bus.imem_WD);
        if (exp_a.size() == 0) begin
          chk("unexpected_write", 32'(bus.imem_WE), 32'd0);
        end else begin
          chk("wr_addr", bus.imem_A, exp_a[0]);
          chk("wr_data", bus.imem_WD, exp_d[0]);
          void'(exp_a.pop_front());
          void'(exp_d.pop_front());
        end
      end
      chk("ready_vs_busy", 32'(bus.rx_ready), 32'(busy && !bus.imem_WE));
      chk("core_en_vs_done", 32'(core_en), 32'(done));
      if (core_en) chk("quiet_in_done", 32'({busy, bus.imem_WE, err}), 32'd0);
      if (post_we) begin
        if (post_last) chk("done_after_last_write", 32'({core_en, done}), 32'd3);
        else           chk("ready_after_write", 32'(bus.rx_ready), 32'd1);
      end
      post_we   = bus.imem_WE;
      post_last = (exp_a.size() == 0);
      pend_we   = 1'b0;
      if (bus.rx_valid && bus.rx_ready) begin
        sess_bytes++;
        if (sess_bytes > 1 && ((sess_bytes - 1) % NB) == 0) pend_we = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    sess_bytes = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("start_to_hdr", 32'({bus.rx_ready, busy, core_en, done, err}), 32'b11000);
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    bit acc = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.rx_valid = 1'b0;
      start = poke && ($urandom_range(0, 2) == 0);
      tick();
      start = 1'b0;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = bus.rx_ready;
      tick();
    end
    bus.rx_valid = 1'b0;
    if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_end(input bit ok);
    bit seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      seen = ok ? done : err;
    end
    chk(ok ? "done_reached" : "err_reached", 32'(seen), 32'd1);
    chk("queue_drained", 32'(exp_a.size()), 32'd0);
    if (ok) chk("final_flags_ok", 32'({core_en, done, err, busy}), 32'b1100);
    else    chk("final_flags_err", 32'({core_en, done, err, busy, bus.imem_WE}), 32'b00100);
    tick();
  endtask

  task automatic load(input int n, input int gmin, input int gmax, input bit poke);
    bit ok = (n >= 1) && (n <= CAP);
    if (ok) begin
      for (int w = 0; w < n; w++) begin
        exp_a.push_back(32'(w * 4));
        exp_d.push_back(word_of(w));
      end
    end
    do_start();
    send_byte(8'(n), 0, 1'b0);
    if (ok) begin
      for (int i = 0; i < n * NB; i++) send_byte(img[i], int'($urandom_range(gmin, gmax)), poke);
    end
    wait_end(ok);
  endtask

  task automatic set_nominal();
    img = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  endtask

  task automatic chk_nominal_log(input string name);
    chk({name, "_count"}, 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk({name, "_a0"}, log_a[0], 32'h0);
      chk({name, "_d0"}, log_d[0], 32'h0000_0013);
      chk({name, "_a1"}, log_a[1], 32'h4);
      chk({name, "_d1"}, log_d[1], 32'h0010_0093);
    end
  endtask

  task automatic fill_random(input int n);
    img.delete();
    for (int i = 0; i < n * NB; i++) img.push_back(8'($urandom));
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    set_nominal();
    chk("model_word0", word_of(0), 32'h0000_0013);
    chk("model_word1", word_of(1), 32'h0010_0093);

    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_zero("idle_outputs");
    end
    tick();

    log_a.delete(); log_d.delete();
    load(2, 0, 0, 1'b0);
    chk_nominal_log("nominal");

    log_a.delete(); log_d.delete();
    load(2, 3, 3, 1'b0);
    chk_nominal_log("stalled");

    load(0, 0, 0, 1'b0);
    load(11, 0, 0, 1'b0);
    fill_random(1);
    load(1, 0, 1, 1'b0);

    set_nominal();
    for (int w = 0; w < 2; w++) begin
      exp_a.push_back(32'(w * 4));
      exp_d.push_back(word_of(w));
    end
    do_start();
    send_byte(8'd2, 0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(img[i], 0, 1'b0);
    rstn = 1'b0;
    #1;
    chk_zero("async_reset");
    exp_a.delete(); exp_d.delete();
    pend_we = 1'b0; post_we = 1'b0; sess_bytes = 0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (10) tick();
    log_a.delete(); log_d.delete();
    load(2, 0, 0, 1'b0);
    chk_nominal_log("after_reset");

    log_a.delete(); log_d.delete();
    load(2, 1, 2, 1'b1);
    chk_nominal_log("busy_start");
    fill_random(3);
    load(3, 0, 1, 1'b0);

    for (int s = 0; s < 25; s++) begin
      int n = int'($urandom_range(0, 12));
      fill_random(n);
      load(n, 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time controller that fills the single-cycle core's instruction memory from a byte-serial host stream, then releases the core. It sits between the external boot link and the instruction memory write port (A/WD/WE). It holds the memory read enable (and core run enable) low until a complete, length-checked image has been written.

## Interface

Parameters:
- DATA_WIDTH, 32, instruction word width; multiple of 8; BPW = DATA_WIDTH/8 bytes per word
- MEM_CAPACITY, 10, instruction memory depth in words; must be ≤ 255

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset; same net as instruction memory reset
- start  in  1  single-cycle request to begin a load
- rx_valid  in  1  host byte valid
- rx_data  in  8  host byte
- rx_ready  out  1  loader can accept a byte this cycle
- imem_A  out  DATA_WIDTH  byte address to instruction memory
- imem_WD  out  DATA_WIDTH  write data to instruction memory
- imem_WE  out  1  write strobe to instruction memory
- core_en  out  1  instruction memory read enable / core run enable
- busy  out  1  load in progress
- done  out  1  image loaded, core running
- err  out  1  header rejected

## Operation

- Byte transfer: a byte is accepted when rx_valid && rx_ready. The host holds rx_data stable while rx_valid && !rx_ready.
- Stream format: 1 header byte N (word count), then N × BPW data bytes, least-significant byte first per word.
- States:
  - IDLE: start → HDR.
  - HDR: rx_ready=1. On accept: if N==0 or N>MEM_CAPACITY, go to ERR; else latch N, clear word_idx and byte_cnt, go to LOAD.
  - LOAD: rx_ready=1. Each accepted byte is shifted into the assembly register at byte lane byte_cnt, then byte_cnt increments. When the BPW-th byte is accepted, go to WRITE and clear byte_cnt.
  - WRITE: rx_ready=0, imem_WE=1 for exactly one cycle, imem_A = word_idx×4 (zero-extended), imem_WD = assembled word. Then word_idx increments. If word_idx+1 == N, go to DONE; else go to LOAD.
  - DONE: core_en=1, done=1. start → HDR, which drops core_en and done.
  - ERR: err=1, core_en=0. start → HDR, which clears err.
- Outputs:
  - busy=1 in HDR, LOAD and WRITE.
  - imem_WE=0 outside WRITE.
  - imem_A/imem_WD are don't-care when imem_WE=0 but are registered, never X after reset.
  - core_en is 0 in every state except DONE, so the memory never reads during writes.
- start is ignored in HDR, LOAD and WRITE. rx_valid is ignored in IDLE, DONE and ERR (rx_ready=0).
- Word count N is interpreted as unsigned 8-bit. word_idx is 8 bits wide. Address arithmetic uses no wrap, because N ≤ MEM_CAPACITY ≤ 255.

## Timing

- Reset values: rx_ready=0, imem_A=0, imem_WD=0, imem_WE=0, core_en=0, busy=0, done=0, err=0; state IDLE; all counters 0.
- start sampled high in cycle t → HDR in t+1, with rx_ready=1 in t+1.
- Last byte of a word accepted in cycle t → imem_WE=1 in t+1 → rx_ready=1 again in t+2.
- Peak throughput is BPW+1 cycles per word.
- Final WRITE in cycle t → core_en=1, done=1 from t+1.
- Reset asserted mid-load: everything returns to reset values immediately (asynchronous). The instruction memory is also cleared by the shared rstn, so a new start is required.
- Stalls (rx_valid low) may occur at any byte position with no loss of state.

## Structure

- Shared package holds:
  - state encoding localparams (IDLE, HDR, LOAD, WRITE, DONE, ERR)
  - BPW
  - header field width (8)
- One sub-module, byte_word_packer: byte_cnt plus lane-write assembly register, with clear and word_full outputs.
- The FSM, word_idx and output registers stay in imem_boot_loader.

## Test plan

- Reset then idle: with rstn low, all outputs are 0. After release with no start, outputs stay 0 for 20 cycles.
- Nominal load: start, then N=2, then bytes 13 00 00 00 93 00 10 00 back-to-back. Required writes: A=0 WD=0x00000013, then A=4 WD=0x00100093, each with WE high one cycle. core_en=1 and done=1 the cycle after the second write.
- Stalled stream: same image with rx_valid deasserted 3 cycles between every byte → identical writes. No WE pulse while a word is incomplete.
- Header errors:
  - N=0 → err=1, no WE pulse.
  - N=11 with MEM_CAPACITY=10 → err=1, no WE pulse.
  - A subsequent start with a valid N=1 image clears err and loads correctly.
- Reset mid-operation: rstn pulsed low after 5 data bytes. Required: all outputs 0 immediately and no WE pulse afterwards. A fresh start and full image then loads from A=0.
- Busy-time start and reload: start pulsed during LOAD is ignored (same write sequence). start in DONE drops core_en next cycle and a new image overwrites from A=0.
